// File: rtl/pio_uart_tx.sv
// Byte-at-a-time UART transmitter fed from a strobeless PIO register.
// A changed byte or a send_req pulse queues the byte; an 8N1 serialiser drains the queue.
module pio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_port,
    input  logic               send_req,
    input  logic               clr_overflow,
    output logic               tx,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]      BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         r_in_q;
    logic               r_send_q;
    logic [7:0]         r_last_q;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_overflow;
    state_t             r_state;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [BW-1:0]      r_baud;
    logic               r_tx;

    logic w_push;
    logic w_full;
    logic w_pop;
    logic w_wr_en;
    logic w_drop;

    // send_req is sampled alongside in_port so a byte and its strobe stay paired.
    assign w_push  = (r_in_q != r_last_q) || r_send_q;
    assign w_full  = (r_level == FULL_LEVEL);
    assign w_pop   = (r_state == IDLE) && (r_level != '0);
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_in_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_q     <= 8'h00;
            r_send_q   <= 1'b0;
            r_last_q   <= 8'h00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_in_q   <= in_port;
            r_send_q <= send_req;
            if (w_push) begin
                r_last_q <= r_in_q;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_wr_en && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_baud    <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_bit_cnt <= 3'd0;
                        r_baud    <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            // tx is registered, so present the bit that becomes shift[0] after this shift.
                            r_tx      <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    r_tx <= 1'b1;
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || (r_level != '0);
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
